counter_cmp_n: RTL and testbench

COUNTER_CMP_N -- requirements
Module: counter_cmp_n

---
 rtl/counter_cmp_n_pkg.sv | 25 ++
 rtl/counter_cmp_n_cmp.sv | 16 +
 rtl/counter_cmp_n.sv | 137 +++++++++++++
 tb/tb_counter_cmp_n.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/counter_cmp_n_pkg.sv
// Shared alarm-clock constants.
// Holds the default counter width, the default terminal count for that
// width, the alarm-clock moduli (seconds/minutes 60, hours 24 and 12) and
// the count-operation encoding used by the counter's next-state logic.
package counter_cmp_n_pkg;

  // Default counter/compare width and its all-ones terminal count.
  localparam int unsigned CNT_WIDTH_DEFAULT = 16;
  localparam logic [CNT_WIDTH_DEFAULT-1:0] CNT_MAX_DEFAULT = '1;

  // Alarm-clock moduli.
  localparam int unsigned SEC_MOD    = 60;
  localparam int unsigned MIN_MOD    = 60;
  localparam int unsigned HOUR24_MOD = 24;
  localparam int unsigned HOUR12_MOD = 12;

  // Operation applied to COUNT on a non-clear edge.
  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_INC  = 2'd2,
    OP_DEC  = 2'd3
  } cnt_op_e;

endpackage

// File: rtl/counter_cmp_n_cmp.sv
// comparator_nbits: parametrised WIDTH-bit equality comparator.
// Ports:
//   a_i  - first operand  (WIDTH)
//   b_i  - second operand (WIDTH)
//   eq_o - 1 when a_i == b_i
module comparator_nbits #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             eq_o
);

  assign eq_o = (a_i == b_i);

endmodule

// File: rtl/counter_cmp_n.sv
// counter_cmp_n: modulo-(MAX+1) up/down counter with load and a compare
// (alarm) register producing a one-cycle Match pulse and a sticky MatchFlag.
// Ports:
//   Clk        - clock, all state updates on the rising edge
//   Clr        - synchronous active-high clear (highest priority)
//   En, Up     - count enable and direction (1 = increment)
//   Load       - load LoadVal (saturated to MAX), beats En
//   LoadVal    - load value (WIDTH)
//   CmpWe      - write CmpVal (saturated to MAX) into the compare register
//   CmpVal     - compare value (WIDTH)
//   Ack        - clears MatchFlag (a same-edge hit wins)
//   COUNT      - current count (registered)
//   Carry      - one-cycle pulse after a wrap in either direction
//   Match      - one-cycle pulse when COUNT newly takes the compare value
//   MatchFlag  - sticky version of Match
module counter_cmp_n
  import counter_cmp_n_pkg::*;
#(
  parameter int               WIDTH = CNT_WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] MAX   = {WIDTH{1'b1}}
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             En,
  input  logic             Up,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  input  logic             CmpWe,
  input  logic [WIDTH-1:0] CmpVal,
  input  logic             Ack,
  output logic [WIDTH-1:0] COUNT,
  output logic             Carry,
  output logic             Match,
  output logic             MatchFlag
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] cmp_q, cmp_d;
  logic             carry_q, carry_d;
  logic             match_q, match_d;
  logic             flag_q, flag_d;

  cnt_op_e          op;
  logic             update;  // COUNT is being written by Load or count
  logic             wrap;
  logic             cmp_eq;
  logic [WIDTH-1:0] load_sat;
  logic [WIDTH-1:0] cmpval_sat;

  assign load_sat   = (LoadVal > MAX) ? MAX : LoadVal;
  assign cmpval_sat = (CmpVal  > MAX) ? MAX : CmpVal;

  always_comb begin
    op = OP_HOLD;
    if (Load) begin
      op = OP_LOAD;
    end else if (En) begin
      op = Up ? OP_INC : OP_DEC;
    end
  end

  // Wrap is detected on the current count, so count_q+1 / count_q-1 are only
  // formed when they stay inside 0..MAX and never overflow WIDTH bits.
  always_comb begin
    count_d = count_q;
    update  = 1'b0;
    wrap    = 1'b0;
    unique case (op)
      OP_LOAD: begin
        count_d = load_sat;
        update  = 1'b1;
      end
      OP_INC: begin
        update = 1'b1;
        if (count_q == MAX) begin
          count_d = '0;
          wrap    = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      OP_DEC: begin
        update = 1'b1;
        if (count_q == '0) begin
          count_d = MAX;
          wrap    = 1'b1;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  // Match looks at the value COUNT is about to take against the compare
  // register as it stands before this edge; a compare write on the same
  // edge only affects later hits.
  comparator_nbits #(
    .WIDTH(WIDTH)
  ) u_cmp (
    .a_i (count_d),
    .b_i (cmp_q),
    .eq_o(cmp_eq)
  );

  always_comb begin
    cmp_d   = CmpWe ? cmpval_sat : cmp_q;
    carry_d = wrap;
    match_d = update & cmp_eq;
    // A new hit beats a simultaneous Ack.
    flag_d  = match_d | (flag_q & ~Ack);
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      count_q <= '0;
      cmp_q   <= MAX;
      carry_q <= 1'b0;
      match_q <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      cmp_q   <= cmp_d;
      carry_q <= carry_d;
      match_q <= match_d;
      flag_q  <= flag_d;
    end
  end

  assign COUNT     = count_q;
  assign Carry     = carry_q;
  assign Match     = match_q;
  assign MatchFlag = flag_q;

endmodule

// File: tb/tb_counter_cmp_n.sv
// Bench for counter_cmp_n at WIDTH=6, MAX=59: directed sequences with literal
// expectations, then randomized stimulus against a behavioural model.
module tb_counter_cmp_n;

  localparam int W   = 6;
  localparam int MAX = 59;

  logic         Clk;
  logic         Clr;
  logic         En;
  logic         Up;
  logic         Load;
  logic [W-1:0] LoadVal;
  logic         CmpWe;
  logic [W-1:0] CmpVal;
  logic         Ack;
  logic [W-1:0] COUNT;
  logic         Carry;
  logic         Match;
  logic         MatchFlag;

  int checks = 0;
  int errors = 0;

  counter_cmp_n #(
    .WIDTH(W),
    .MAX  (6'd59)
  ) dut (
    .Clk      (Clk),
    .Clr      (Clr),
    .En       (En),
    .Up       (Up),
    .Load     (Load),
    .LoadVal  (LoadVal),
    .CmpWe    (CmpWe),
    .CmpVal   (CmpVal),
    .Ack      (Ack),
    .COUNT    (COUNT),
    .Carry    (Carry),
    .Match    (Match),
    .MatchFlag(MatchFlag)
  );

  // ---------------- clock / initial input values ----------------
  initial begin
    Clk     = 1'b0;
    Clr     = 1'b1;
    En      = 1'b0;
    Up      = 1'b1;
    Load    = 1'b0;
    LoadVal = '0;
    CmpWe   = 1'b0;
    CmpVal  = '0;
    Ack     = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + scoreboard ----------------
  // Model state, in plain integers: count modulo MAX+1, compare value, pulses.
  int m_count = 0;
  int m_cmp   = MAX;
  int m_carry = 0;
  int m_match = 0;
  int m_flag  = 0;
  logic [W+2:0] exp_q[$];

  function automatic int sat(input int v);
    return (v > MAX) ? MAX : v;
  endfunction

  always @(posedge Clk) begin
    int nxt;
    int upd;
    logic [W+2:0] e;
    if (Clr) begin
      m_count = 0; m_cmp = MAX; m_carry = 0; m_match = 0; m_flag = 0;
    end else begin
      nxt = m_count; upd = 0; m_carry = 0;
      if (Load) begin
        nxt = sat(int'(LoadVal)); upd = 1;
      end else if (En) begin
        upd = 1;
        if (Up) begin
          nxt = (m_count + 1) % (MAX + 1);
          m_carry = (m_count == MAX) ? 1 : 0;
        end else begin
          nxt = (m_count + MAX) % (MAX + 1);
          m_carry = (m_count == 0) ? 1 : 0;
        end
      end
      // A hit compares against the compare value held before this edge.
      m_match = (upd == 1 && nxt == m_cmp) ? 1 : 0;
      if (m_match == 1) m_flag = 1;
      else if (Ack) m_flag = 0;
      if (CmpWe) m_cmp = sat(int'(CmpVal));
      m_count = nxt;
    end
    exp_q.push_back({m_flag[0], m_match[0], m_carry[0], m_count[W-1:0]});
    #1;
    e = exp_q.pop_front();
    check("count",     int'(COUNT),     int'(e[W-1:0]));
    check("carry",     int'(Carry),     int'(e[W]));
    check("match",     int'(Match),     int'(e[W+1]));
    check("matchflag", int'(MatchFlag), int'(e[W+2]));
  end

  // ---------------- driver ----------------
  // Drive on the falling edge, return 2 time units after the next rising edge.
  task automatic cyc(input logic clr, input logic en, input logic up,
                     input logic ld, input logic [W-1:0] lv,
                     input logic we, input logic [W-1:0] cv, input logic ack);
    @(negedge Clk);
    Clr = clr; En = en; Up = up; Load = ld; LoadVal = lv;
    CmpWe = we; CmpVal = cv; Ack = ack;
    @(posedge Clk);
    #2;
  endtask

  // ---------------- directed + random sequences ----------------
  initial begin
    // Clear for two cycles.
    cyc(1, 0, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 0, 0);
    check("rst_count", int'(COUNT), 0);
    check("rst_carry", int'(Carry), 0);
    check("rst_match", int'(Match), 0);
    check("rst_flag",  int'(MatchFlag), 0);

    // 61 up counts: 1..59, 0, 1 with Carry only on the 0 after 59.
    for (int i = 1; i <= 61; i++) begin
      cyc(0, 1, 1, 0, 0, 0, 0, 0);
      check("up_count", int'(COUNT), (i == 60) ? 0 : ((i == 61) ? 1 : i));
      check("up_carry", int'(Carry), (i == 60) ? 1 : 0);
    end

    // Down from 0 wraps to 59 with one Carry pulse.
    cyc(1, 0, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    check("dn_count", int'(COUNT), 59);
    check("dn_carry", int'(Carry), 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    check("dn_carry_off", int'(Carry), 0);

    // Compare at 7: single Match, sticky flag, Ack, second hit with Ack.
    cyc(1, 0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 1, 7, 0);
    for (int i = 1; i <= 10; i++) begin
      cyc(0, 1, 1, 0, 0, 0, 0, 0);
      check("cmp7_match", int'(Match), (i == 7) ? 1 : 0);
      check("cmp7_flag",  int'(MatchFlag), (i >= 7) ? 1 : 0);
    end
    cyc(0, 0, 1, 0, 0, 0, 0, 1);
    check("ack_clears", int'(MatchFlag), 0);
    for (int i = 0; i < 56; i++) cyc(0, 1, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0, 0, 1);
    check("hit2_count", int'(COUNT), 7);
    check("hit2_match", int'(Match), 1);
    check("hit2_flag_ack", int'(MatchFlag), 1);

    // Holding at the compare value does not re-assert Match.
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1, 0, 0, 0, 0, 0);
      check("hold_match", int'(Match), 0);
    end

    // Load saturates; Load beats En and never makes Carry.
    cyc(0, 0, 1, 1, 63, 0, 0, 0);
    check("load_sat", int'(COUNT), 59);
    cyc(0, 1, 1, 1, 20, 0, 0, 0);
    check("load_en_count", int'(COUNT), 20);
    check("load_en_carry", int'(Carry), 0);

    // Clear at 58 with En, flag set and a compare write: all cleared.
    cyc(0, 0, 1, 1, 7, 0, 0, 0);
    check("load_hit", int'(Match), 1);
    cyc(0, 0, 1, 1, 58, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 1, 3, 0);
    check("clr_count", int'(COUNT), 0);
    check("clr_carry", int'(Carry), 0);
    check("clr_match", int'(Match), 0);
    check("clr_flag",  int'(MatchFlag), 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    check("clr_cmp_is_max", int'(Match), 1);

    // Compare write equal to COUNT: no Match; Load of same value: Match.
    cyc(1, 0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 1, 0, 0);
    check("cmpwe_eq_nomatch", int'(Match), 0);
    cyc(0, 0, 1, 1, 0, 0, 0, 0);
    check("load_same_match", int'(Match), 1);
    cyc(1, 0, 1, 0, 0, 0, 0, 0);
    check("clr_zero_nomatch", int'(Match), 0);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      cyc(($urandom_range(0, 39) == 0),
          ($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 1)),
          ($urandom_range(0, 9) == 0),
          W'($urandom_range(0, 63)),
          ($urandom_range(0, 11) == 0),
          W'($urandom_range(0, 63)),
          ($urandom_range(0, 5) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
